// File: rtl/voice_pkg.sv
// Shared constants, state types and payload helper for the voice status receiver.
package voice_pkg;

    localparam logic [7:0] VOICE_HDR        = 8'hAA;
    localparam logic [7:0] VOICE_CMD_STATUS = 8'h41;
    localparam logic [7:0] VOICE_CMD_DONE   = 8'h3D;
    localparam int         VOICE_MAX_LEN    = 4;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_LEN,
        P_DATA,
        P_CHK
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Payload bytes arrive right-justified; move the first byte to [31:24].
    function automatic logic [31:0] voice_align(input logic [31:0] d,
                                                input logic [2:0]  len);
        logic [31:0] r;
        r = '0;
        case (len)
            3'd1:    r = {d[7:0], 24'h0};
            3'd2:    r = {d[15:0], 16'h0};
            3'd3:    r = {d[23:0], 8'h0};
            3'd4:    r = d;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/voice_uart_rx.sv
// 8N1 UART byte receiver with 2-FF input synchronizer.
module voice_uart_rx
    import voice_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_rx,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic [7:0] byte_data
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic sync1, sync2, prev;
    logic fall;

    rx_state_t     state, state_n;
    logic [CW-1:0] clk_cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          bv_n, fe_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= data_rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_ferr  <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= cnt_n;
            bit_cnt    <= bit_n;
            shreg      <= sh_n;
            byte_valid <= bv_n;
            byte_ferr  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = (clk_cnt == FULL) ? '0 : clk_cnt + 1'b1;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        bv_n    = 1'b0;
        fe_n    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START: begin
                // Mid start bit: a high line here means it was only a glitch.
                if (clk_cnt == HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL) begin
                    sh_n  = {sync2, shreg[7:1]};
                    bit_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL) begin
                    state_n = RX_IDLE;
                    bv_n    = sync2;
                    fe_n    = ~sync2;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/voice_status_rx.sv
// Voice module status-frame receiver: UART bytes -> validated frames, play_busy.
// Define VOICE_RX_CHKSUM_EN to enforce the frame checksum.
module voice_status_rx
    import voice_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_CYC  = 520800
) (
    input  logic        clk_50M,
    input  logic        s_rst,
    input  logic        data_rx,
    output logic        frame_valid,
    output logic [7:0]  frame_cmd,
    output logic [2:0]  frame_len,
    output logic [31:0] frame_data,
    output logic        frame_err,
    output logic        play_busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

    logic       byte_valid, byte_ferr;
    logic [7:0] byte_data;

    voice_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk_50M),
        .rst       (s_rst),
        .data_rx   (data_rx),
        .byte_valid(byte_valid),
        .byte_ferr (byte_ferr),
        .byte_data (byte_data)
    );

    parse_state_t pstate, pstate_n;
    logic [7:0]   cmd_q, cmd_n;
    logic [2:0]   len_q, len_n;
    logic [2:0]   rem_q, rem_n;
    logic [31:0]  data_q, data_n;
    logic [7:0]   sum_q, sum_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic         timeout, good, bad;
    logic [31:0]  payload;

    assign payload = voice_align(data_q, len_q);
    // A byte arriving in the same cycle always beats the timeout.
    assign timeout = (pstate != P_HDR) && (tmo_cnt == TMO) && !byte_valid;

    always_ff @(posedge clk_50M or posedge s_rst) begin
        if (s_rst) begin
            pstate  <= P_HDR;
            cmd_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            pstate  <= pstate_n;
            cmd_q   <= cmd_n;
            len_q   <= len_n;
            rem_q   <= rem_n;
            data_q  <= data_n;
            sum_q   <= sum_n;
            tmo_cnt <= tmo_n;
        end
    end

    always_comb begin
        pstate_n = pstate;
        cmd_n    = cmd_q;
        len_n    = len_q;
        rem_n    = rem_q;
        data_n   = data_q;
        sum_n    = sum_q;
        good     = 1'b0;
        bad      = 1'b0;
        if (pstate == P_HDR || byte_valid) tmo_n = '0;
        else if (tmo_cnt == TMO)           tmo_n = tmo_cnt;
        else                               tmo_n = tmo_cnt + 1'b1;

        if (byte_valid) begin
            unique case (pstate)
                P_HDR: begin
                    if (byte_data == VOICE_HDR) begin
                        pstate_n = P_CMD;
                        data_n   = '0;
                    end
                end
                P_CMD: begin
                    cmd_n    = byte_data;
                    sum_n    = byte_data;
                    pstate_n = P_LEN;
                end
                P_LEN: begin
                    if (byte_data > 8'(VOICE_MAX_LEN)) begin
                        bad      = 1'b1;
                        pstate_n = P_HDR;
                    end else begin
                        len_n    = byte_data[2:0];
                        rem_n    = byte_data[2:0];
                        sum_n    = sum_q + byte_data;
                        pstate_n = (byte_data == 8'd0) ? P_CHK : P_DATA;
                    end
                end
                P_DATA: begin
                    data_n = {data_q[23:0], byte_data};
                    sum_n  = sum_q + byte_data;
                    rem_n  = rem_q - 3'd1;
                    if (rem_q == 3'd1) pstate_n = P_CHK;
                end
                P_CHK: begin
                    pstate_n = P_HDR;
`ifdef VOICE_RX_CHKSUM_EN
                    good = (byte_data == sum_q);
                    bad  = (byte_data != sum_q);
`else
                    good = 1'b1;
`endif
                end
                default: pstate_n = P_HDR;
            endcase
        end else if (byte_ferr && pstate != P_HDR) begin
            bad      = 1'b1;
            pstate_n = P_HDR;
        end else if (timeout) begin
            bad      = 1'b1;
            pstate_n = P_HDR;
        end
    end

    always_ff @(posedge clk_50M or posedge s_rst) begin
        if (s_rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            frame_data  <= '0;
            play_busy   <= 1'b0;
        end else begin
            frame_valid <= good;
            frame_err   <= bad;
            if (good) begin
                frame_cmd  <= cmd_q;
                frame_len  <= len_q;
                frame_data <= payload;
                if (cmd_q == VOICE_CMD_STATUS && len_q != 3'd0) begin
                    if (payload[31:24] == 8'h01)      play_busy <= 1'b1;
                    else if (payload[31:24] == 8'h00) play_busy <= 1'b0;
                end else if (cmd_q == VOICE_CMD_DONE) begin
                    play_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/voice_status_rx.md
# voice_status_rx

Serial receiver and frame parser for the return line of the voice playback module. It samples the module's 9600-baud 8N1 UART output, assembles bytes into status frames and validates each frame. Each good frame is presented as a one-cycle strobe with command and payload; `play_busy` is maintained from play-status frames. It sits beside the voice transmit path, so the control logic can gate new `select_voice` requests on real playback state.

## Interface
- `CLKS_PER_BIT`, 5208: `clk_50M` cycles per UART bit (50 MHz / 9600).
- `TIMEOUT_CYC`, 520800: idle cycles allowed between bytes of one frame (≈10 byte times).
- `clk_50M`  in  1  system clock, 50 MHz.
- `s_rst`  in  1  reset, asynchronous, active-high.
- `data_rx`  in  1  UART line from voice module; asynchronous, idle high.
- `frame_valid`  out  1  one-cycle strobe; `frame_cmd`/`frame_len`/`frame_data` valid this cycle.
- `frame_cmd`  out  8  command byte of last good frame.
- `frame_len`  out  3  payload byte count, 0–4.
- `frame_data`  out  32  payload; first byte in [31:24], unused low bytes zero.
- `frame_err`  out  1  one-cycle strobe on bad length, checksum, stop bit or timeout.
- `play_busy`  out  1  1 while the module reports playback in progress.

## Operation
- **Input sync:** `data_rx` passes through a 2-FF synchronizer. The synchronizer resets to 1.
- **Byte receiver states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - START: at `CLKS_PER_BIT/2` the line is re-sampled. If high, it was a glitch → IDLE. If low → DATA.
  - DATA: 8 bits are sampled at full-bit spacing, LSB first.
  - STOP: the stop bit is sampled. If 1, a one-cycle `byte_valid` is emitted with the byte. If 0, a `byte_ferr` is emitted and no byte is produced. Either way → IDLE.
- **Frame format:** `0xAA`, `cmd`, `len`, `len` data bytes, `chk`.
  - `chk` = (`cmd` + `len` + data bytes) mod 256.
- **Parser states:** HDR, CMD, LEN, DATA, CHK.
  - HDR: bytes other than `0xAA` are silently discarded.
  - LEN: `len` > 4 → `frame_err`, → HDR.
  - LEN with `len` = 0 goes directly to CHK.
  - CHK: on a checksum match, the outputs are updated and `frame_valid` pulses; otherwise `frame_err` pulses. Either way → HDR.
- **Errors mid-frame:** a `byte_ferr` in any state other than HDR → `frame_err`, → HDR.
- **Timeout:** a counter restarts on every accepted byte. When it reaches `TIMEOUT_CYC` in a state other than HDR → `frame_err`, → HDR.
- **play_busy:**
  - Set on a good frame with `cmd` = `0x41` and first data byte = `0x01`.
  - Cleared on `0x41` with first data byte = `0x00`, and on `cmd` = `0x3D` (play finished).
  - Other commands leave it unchanged.
- **Data-bus widths:** the checksum accumulator is 8 bits and wraps. `frame_data` is shifted in MSB-first.

## Timing
- All outputs reset to 0. The receiver resets to IDLE, the parser to HDR, and all counters to 0.
- The bit counter counts 0..`CLKS_PER_BIT`-1 and wraps.
- Sample points are counted from the detected falling edge:
  - start bit: `CLKS_PER_BIT/2`
  - data bit n: `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`
- Latency:
  - `byte_valid` comes at the stop-bit sample cycle + 1.
  - `frame_valid`/`frame_err` come one cycle after the `byte_valid` of the `chk` byte.
  - `play_busy` updates in the same cycle as `frame_valid`.
- `frame_valid` and `frame_err` are never high together.
- A timeout and a `byte_valid` in the same cycle: the byte wins.
- Back-to-back frames with zero idle gap must be received with no loss.
- An asserted `s_rst` aborts any byte or frame in progress immediately. No strobe is emitted for the aborted byte or frame.

## Configuration
- `VOICE_RX_CHKSUM_EN` defined: the checksum is compared as above.
- Undefined: the `chk` byte is still consumed but ignored, and every frame with a legal length is reported as `frame_valid`.

## Structure
- Shared package `voice_pkg`:
  - `VOICE_HDR` = 8'hAA
  - `VOICE_CMD_STATUS` = 8'h41
  - `VOICE_CMD_DONE` = 8'h3D
  - `VOICE_MAX_LEN` = 4
  - parser state enumeration
- One sub-module, `voice_uart_rx`. It contains the synchronizer and the byte receiver, and outputs `byte_valid`, `byte_ferr` and `byte_data[7:0]`. The parser and `play_busy` logic live in `voice_status_rx`.

## Test plan
- `AA 41 01 01 43` at 9600 baud → one `frame_valid`, `frame_cmd`=0x41, `frame_len`=1, `frame_data`=0x01000000, `play_busy`=1.
- Then `AA 3D 00 3D` → `frame_valid`, `frame_len`=0, `play_busy`=0.
- `AA 41 01 01 44` → `frame_err` with the macro defined and `play_busy` unchanged; `frame_valid` with the macro undefined.
- `AA 20 05 ...` → `frame_err` right after the `len` byte; a following good frame is received correctly.
- A 1-µs low glitch on idle `data_rx` → no byte. Then `AA 41` followed by 600000 idle cycles → exactly one `frame_err` at `TIMEOUT_CYC`.
- Stop bit forced to 0 on the `cmd` byte → `frame_err`.
- `s_rst` pulse in the middle of a frame → outputs 0; the next full frame is decoded correctly.
